dma_channel_ctrl: RTL and testbench

//  Single-channel fly-by DMA controller for IO-to-memory (DMA write) transfers.
//  - Sits between the IO device (DREQ/DACK) and the shared memory bus.
//  - Obtains the bus from the CPU via HOLD/HLDA and asserts DACK so the IO device drives Data_Bus.
//  - Per transfer: drives the memory address, MEMW and the IReady/TReady handshake; counts transfers and flags terminal count.

---
 rtl/dma_channel_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dma_channel_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_ctrl.sv
// Single-channel fly-by DMA controller for IO-to-memory writes.
// Requests the bus with HOLD/HLDA, acknowledges the IO device with DACK and
// sequences the IReady/TReady handshake once per transfer.
module dma_channel_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [15:0]       cfg_data,
  input  logic              DREQ,
  output logic              DACK,
  output logic              HOLD,
  input  logic              HLDA,
  output logic [ADDR_W-1:0] Address_Bus,
  output logic              Addr_OE,
  output logic              MEMW,
  output logic              IReady,
  input  logic              TReady,
  output logic              TC,
  output logic              busy,
  output logic              err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StReq, StXfer, StRelease, StStep, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d, cur_addr_q, cur_addr_d;
  logic [COUNT_W-1:0]  count_q, count_d, cur_count_q, cur_count_d;
  logic [2:0]          ctrl_q, ctrl_d;  // {autoinit, incr, enable}
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [COUNT_W-1:0]  cnt_dec;

  assign cnt_dec = cur_count_q - COUNT_W'(1);

  // State and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      count_q     <= '0;
      cur_addr_q  <= '0;
      cur_count_q <= '0;
      ctrl_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      cur_addr_q  <= cur_addr_d;
      cur_count_q <= cur_count_d;
      ctrl_q      <= ctrl_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
    end
  end

  // Config decode, next-state logic and Moore outputs
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    cur_addr_d  = cur_addr_q;
    cur_count_d = cur_count_q;
    ctrl_d      = ctrl_q;
    tmo_d       = tmo_q + TmoW'(1);
    err_d       = err_q;
    HOLD        = 1'b0;
    DACK        = 1'b0;
    Addr_OE     = 1'b0;
    MEMW        = 1'b0;
    IReady      = 1'b0;
    TC          = 1'b0;

    if (cfg_we) begin
      if (state_q == StIdle) begin
        unique case (cfg_sel)
          2'd0: begin
            base_d     = ADDR_W'(cfg_data);
            cur_addr_d = ADDR_W'(cfg_data);
          end
          2'd1: begin
            count_d     = COUNT_W'(cfg_data);
            cur_count_d = COUNT_W'(cfg_data);
          end
          2'd2: begin
            ctrl_d = cfg_data[2:0];
            err_d  = 1'b0;
          end
          default: ;
        endcase
      end else if (cfg_sel == 2'd2 && !cfg_data[0]) begin
        // Disable while busy: the channel finishes the current transfer and
        // stops at the next STEP because enable is no longer set.
        ctrl_d = cfg_data[2:0];
        err_d  = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (ctrl_q[0] && DREQ && cur_count_q != '0) state_d = StReq;
      end
      StReq: begin
        HOLD = 1'b1;
        if (HLDA) begin
          state_d = StXfer;
          tmo_d   = '0;
        end
      end
      StXfer: begin
        HOLD    = 1'b1;
        DACK    = 1'b1;
        Addr_OE = 1'b1;
        MEMW    = 1'b1;
        IReady  = 1'b1;
        if (TReady) begin
          state_d = StRelease;
          tmo_d   = '0;
        end else if (!HLDA || tmo_q == TmoLast) begin
          state_d = StErr;
        end
      end
      StRelease: begin
        HOLD    = 1'b1;
        DACK    = 1'b1;
        Addr_OE = 1'b1;
        MEMW    = 1'b1;
        if (!TReady) begin
          state_d = StStep;
        end else if (!HLDA || tmo_q == TmoLast) begin
          state_d = StErr;
        end
      end
      StStep: begin
        HOLD        = 1'b1;
        cur_count_d = cnt_dec;
        if (ctrl_q[1]) cur_addr_d = cur_addr_q + ADDR_W'(1);
        if (cnt_dec == '0) begin
          state_d = StDone;
        end else if (DREQ && ctrl_q[0]) begin
          state_d = StXfer;
          tmo_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: begin
        TC      = 1'b1;
        state_d = StIdle;
        if (ctrl_q[2]) begin
          cur_addr_d  = base_q;
          cur_count_d = count_q;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
      StErr: begin
        ctrl_d[0] = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Error is raised on entry so it is visible during the ERR cycle itself
    if (state_d == StErr) err_d = 1'b1;
  end

  assign Address_Bus = Addr_OE ? cur_addr_q : '0;
  assign busy        = (state_q != StIdle);
  assign err         = err_q;

endmodule

// File: tb/tb_dma_channel_ctrl.sv
// Scoreboard bench for dma_channel_ctrl: stimulus pushes expected bus events,
// a monitor pops and compares them as the DUT produces them.
module tb_dma_channel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        DREQ;
  logic        DACK, HOLD, HLDA, Addr_OE, MEMW, IReady, TReady, TC, busy, err;
  logic [15:0] Address_Bus;
  int          mem_mode;  // 0 zero-wait echo, 1 TReady stuck low, 2 stuck high

  int checks   = 0;
  int failures = 0;

  // kind 0 transfer {DACK,MEMW,Addr_OE,addr}; 1 TC {DACK,HOLD,IReady}; 2 err
  typedef struct packed {
    logic [1:0]  kind;
    logic [18:0] data;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  assign HLDA   = HOLD;
  assign TReady = (mem_mode == 0) ? IReady : (mem_mode == 2);

  dma_channel_ctrl #(
    .ADDR_W (16),
    .COUNT_W(16),
    .TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .DREQ       (DREQ),
    .DACK       (DACK),
    .HOLD       (HOLD),
    .HLDA       (HLDA),
    .Address_Bus(Address_Bus),
    .Addr_OE    (Addr_OE),
    .MEMW       (MEMW),
    .IReady     (IReady),
    .TReady     (TReady),
    .TC         (TC),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_addr(input logic [15:0] a);
    exp_q.push_back('{kind: 2'd0, data: {3'b111, a}});
  endtask

  task automatic push_tc();
    exp_q.push_back('{kind: 2'd1, data: 19'd0});
  endtask

  task automatic push_err();
    exp_q.push_back('{kind: 2'd2, data: 19'd0});
  endtask

  // Monitor: one event per transfer start, TC pulse or err rising edge
  logic prev_ir = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    ev_t got, want;
    if (rst_n) begin
      if (IReady && !prev_ir) begin
        got = '{kind: 2'd0, data: {DACK, MEMW, Addr_OE, Address_Bus}};
        if (exp_q.size() == 0) chk("unexpected_xfer", {13'd0, got}, 32'hFFFF_FFFF);
        else begin want = exp_q.pop_front(); chk("xfer_event", {11'd0, got}, {11'd0, want}); end
      end
      if (TC) begin
        got = '{kind: 2'd1, data: {DACK, HOLD, IReady, 16'h0}};
        if (exp_q.size() == 0) chk("unexpected_tc", {13'd0, got}, 32'hFFFF_FFFF);
        else begin want = exp_q.pop_front(); chk("tc_event", {11'd0, got}, {11'd0, want}); end
      end
      if (err && !prev_err) begin
        got = '{kind: 2'd2, data: {DACK, HOLD, IReady, 16'h0}};
        if (exp_q.size() == 0) chk("unexpected_err", {13'd0, got}, 32'hFFFF_FFFF);
        else begin want = exp_q.pop_front(); chk("err_event", {11'd0, got}, {11'd0, want}); end
      end
    end
    prev_ir  = IReady;
    prev_err = err;
  end

  task automatic cfg(input logic [1:0] sel, input logic [15:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic setup(input logic [15:0] base, input logic [15:0] cnt, input logic [2:0] ctl);
    cfg(2'd0, base);
    cfg(2'd1, cnt);
    cfg(2'd2, {13'd0, ctl});
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return IReady;
      1:       return busy;
      2:       return TC;
      3:       return err;
      default: return DACK & ~IReady;
    endcase
  endfunction

  task automatic wait_until(input string nm, input int sel, input logic val);
    int n = 0;
    while (sig(sel) !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(nm, {31'd0, sig(sel)}, {31'd0, val});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; DREQ = 1'b0; mem_mode = 0;
    #3;
    chk("reset_outputs", {DACK, HOLD, Addr_OE, MEMW, IReady, TC, busy, err}, 0);
    chk("reset_addr", Address_Bus, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    chk("idle_after_reset", {HOLD, busy}, 0);

    // 1: two-transfer burst, enable clears at DONE
    setup(16'h0100, 16'd2, 3'b011);
    push_addr(16'h0100); push_addr(16'h0101); push_tc();
    DREQ = 1'b1;
    drain("t1_drain");
    idle_cycles(5);
    chk("t1_enable_cleared", {HOLD, busy}, 0);
    DREQ = 1'b0;
    idle_cycles(2);

    // 2: DREQ drops after first transfer, resumes later
    setup(16'h0200, 16'd3, 3'b011);
    push_addr(16'h0200); push_addr(16'h0201); push_addr(16'h0202); push_tc();
    DREQ = 1'b1;
    wait_until("t2_first_xfer", 0, 1'b1);
    DREQ = 1'b0;
    wait_until("t2_to_idle", 1, 1'b0);
    chk("t2_hold_released", HOLD, 0);
    idle_cycles(3);
    chk("t2_stays_idle", {HOLD, busy}, 0);
    chk("t2_pending", exp_q.size(), 3);
    DREQ = 1'b1;
    drain("t2_drain");
    DREQ = 1'b0;
    idle_cycles(3);

    // 3: memory never acknowledges -> timeout
    mem_mode = 1;
    setup(16'h0300, 16'd1, 3'b011);
    push_addr(16'h0300); push_err();
    DREQ = 1'b1;
    wait_until("t3_xfer", 0, 1'b1);
    n = 0;
    while (IReady && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t3_wait_cycles", n, 15);
    chk("t3_err_set", err, 1);
    chk("t3_bus_quiet", {DACK, HOLD, IReady, Addr_OE, MEMW, TC}, 0);
    DREQ = 1'b0;
    mem_mode = 0;
    idle_cycles(3);
    chk("t3_err_sticky", {err, busy}, 2'b10);
    cfg(2'd2, 16'd0);
    chk("t3_err_cleared", err, 0);
    drain("t3_drain");

    // 4: address wrap
    setup(16'hFFFF, 16'd2, 3'b011);
    push_addr(16'hFFFF); push_addr(16'h0000); push_tc();
    DREQ = 1'b1;
    drain("t4_drain");
    DREQ = 1'b0;
    idle_cycles(3);

    // 5: autoinit single transfer, repeats same address
    setup(16'h0400, 16'd1, 3'b111);
    push_addr(16'h0400); push_tc();
    DREQ = 1'b1;
    drain("t5_first");
    DREQ = 1'b0;
    idle_cycles(3);
    chk("t5_idle_between", busy, 0);
    push_addr(16'h0400); push_tc();
    DREQ = 1'b1;
    drain("t5_second");
    DREQ = 1'b0;
    idle_cycles(2);
    cfg(2'd2, 16'd0);
    idle_cycles(2);

    // 6: asynchronous reset in RELEASE
    mem_mode = 2;
    setup(16'h0500, 16'd4, 3'b011);
    push_addr(16'h0500);
    DREQ = 1'b1;
    wait_until("t6_release", 4, 1'b1);
    chk("t6_in_release", {DACK, IReady, HOLD}, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outputs", {DACK, HOLD, Addr_OE, MEMW, IReady, TC, busy, err}, 0);
    chk("t6_async_addr", Address_Bus, 0);
    mem_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);
    chk("t6_disabled_after_reset", {HOLD, busy}, 0);
    DREQ = 1'b0;
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
